// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - parametrised UART receiver with valid/ready output, error flags and overrun pulse
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_core #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 1,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic       brk_det
);

  localparam int BAUD_CLKS = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW        = (BAUD_CLKS > 2) ? $clog2(BAUD_CLKS) : 1;
  localparam logic [CW-1:0] FULL_M1   = CW'(BAUD_CLKS - 1);
  localparam logic [CW-1:0] HALF_M1   = CW'(BAUD_CLKS / 2 - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_RX_BREAK_DET_EN
    , S_BREAK
`endif
  } state_t;

  state_t                 r_state, w_next;
  logic                   r_sync1, r_rxs;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_bit_idx;
  logic                   r_stop_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_xor, r_perr_acc, r_ferr_acc, r_armed, r_commit;
  logic [7:0]             r_data;
  logic                   r_valid, r_perr, r_ferr, r_ovr;
  logic                   w_bit_end, w_half, w_shift, w_par_smp, w_stop_smp, w_commit;

  assign w_bit_end = (r_cnt == FULL_M1);
  assign w_half    = (r_cnt == HALF_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_rxs   <= r_sync1;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic r_par_bit, r_brk, w_brk, w_zero_frame;
  assign w_zero_frame = (r_shift == '0) && !r_rxs && ((PARITY_EN == 0) || !r_par_bit);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_shift    = 1'b0;
    w_par_smp  = 1'b0;
    w_stop_smp = 1'b0;
    w_commit   = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    w_brk      = 1'b0;
`endif
    case (r_state)
      // r_armed blocks a restart while the line is still low after a bad stop bit
      S_IDLE:  if (!r_rxs && r_armed) w_next = S_START;
      S_START: if (w_half) w_next = r_rxs ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_bit_end) begin
          w_shift = 1'b1;
          if (r_bit_idx == LAST_BIT) w_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_par_smp = 1'b1;
          w_next    = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_stop_smp = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
          if (!r_stop_idx && w_zero_frame) begin
            w_brk  = 1'b1;
            w_next = S_BREAK;
          end else
`endif
          if (r_stop_idx == LAST_STOP) begin
            w_commit = 1'b1;
            w_next   = S_IDLE;
          end
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      S_BREAK: if (r_rxs) w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_xor      <= 1'b0;
      r_perr_acc <= 1'b0;
      r_ferr_acc <= 1'b0;
      r_armed    <= 1'b1;
      r_commit   <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      r_par_bit  <= 1'b0;
      r_brk      <= 1'b0;
`endif
    end else begin
      r_commit <= w_commit;
`ifdef UART_RX_BREAK_DET_EN
      r_brk    <= w_brk;
`endif
      if (r_state == S_IDLE || w_next != r_state || w_bit_end) r_cnt <= '0;
      else                                                     r_cnt <= r_cnt + CW'(1);
      if (r_state == S_IDLE) begin
        r_bit_idx  <= '0;
        r_stop_idx <= 1'b0;
        r_xor      <= 1'b0;
        r_perr_acc <= 1'b0;
        r_ferr_acc <= 1'b0;
      end
      if (w_shift) begin
        r_shift   <= {r_rxs, r_shift[DATA_BITS-1:1]};
        r_xor     <= r_xor ^ r_rxs;
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_par_smp) begin
        r_perr_acc <= (r_rxs != (r_xor ^ ODD));
`ifdef UART_RX_BREAK_DET_EN
        r_par_bit  <= r_rxs;
`endif
      end
      if (w_stop_smp) begin
        r_stop_idx <= ~r_stop_idx;
        if (!r_rxs) r_ferr_acc <= 1'b1;
      end
      if (w_stop_smp && !r_rxs) r_armed <= 1'b0;
      else if (r_rxs)           r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (r_valid && rx_ready) r_valid <= 1'b0;
      if (r_commit) begin
        if (!r_valid || rx_ready) begin
          r_data  <= 8'(r_shift);
          r_perr  <= r_perr_acc;
          r_ferr  <= r_ferr_acc;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;
  assign busy       = (r_state != S_IDLE);
`ifdef UART_RX_BREAK_DET_EN
  assign brk_det    = r_brk;
`else
  assign brk_det    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed self-checking bench for uart_rx_core (8E1 and 7N2 instances)
// Break expectations follow UART_RX_BREAK_DET_EN.
module tb_uart_rx_core;

  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int BC     = 100;
`ifdef UART_RX_BREAK_DET_EN
  localparam int BRK_WORDS = 0;
  localparam int BRK_PULSES = 1;
`else
  localparam int BRK_WORDS = 1;
  localparam int BRK_PULSES = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, rx_in, rx_ready, rx_in2, rx_ready2;
  logic [7:0] rx_data, rx_data2;
  logic       rx_valid, parity_err, frame_err, overrun, busy, brk_det;
  logic       rx_valid2, parity_err2, frame_err2, overrun2, busy2, brk_det2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int frame_start = 0;

  int         n_acc = 0, n_ovr = 0, n_brk = 0, n_busy = 0, rise_cyc = 0;
  logic [7:0] acc_data = 8'h00;
  logic       acc_perr = 1'b0, acc_ferr = 1'b0, prev_valid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_core #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) u_dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .busy(busy), .brk_det(brk_det)
  );

  uart_rx_core #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY_EN(0),
                 .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .rx_in(rx_in2), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .rx_ready(rx_ready2), .parity_err(parity_err2), .frame_err(frame_err2),
    .overrun(overrun2), .busy(busy2), .brk_det(brk_det2)
  );

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      if (rx_valid && rx_ready) begin
        n_acc++;
        acc_data = rx_data;
        acc_perr = parity_err;
        acc_ferr = frame_err;
      end
      if (overrun) n_ovr++;
      if (brk_det) n_brk++;
      if (busy) n_busy++;
      prev_valid = rx_valid;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input int which, input logic b);
    if (which == 0) rx_in = b;
    else            rx_in2 = b;
    repeat (BC) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] data, input int nbits,
                            input logic has_par, input logic par, input logic stop1,
                            input logic stop2, input int nstop);
    @(negedge clk);
    if (which == 0) frame_start = cyc + 1;
    drive_bit(which, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(which, data[i]);
    if (has_par) drive_bit(which, par);
    drive_bit(which, stop1);
    if (nstop == 2) drive_bit(which, stop2);
    if (which == 0) rx_in = 1'b1;
    else            rx_in2 = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_in = 1'b1; rx_in2 = 1'b1; rx_ready = 1'b1; rx_ready2 = 1'b0;
    wait_clks(5);
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
    tests++; if (parity_err !== 1'b0) begin fails++; $display("FAIL reset_parity_err got %b exp 0", parity_err); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (brk_det !== 1'b0) begin fails++; $display("FAIL reset_brk_det got %b exp 0", brk_det); end
    tests++; if ({rx_data2, rx_valid2, busy2, overrun2, brk_det2} !== 12'h000) begin
      fails++; $display("FAIL reset_dut2 got %h exp 000", {rx_data2, rx_valid2, busy2, overrun2, brk_det2});
    end
    rst = 1'b0;
    wait_clks(BC);
  endtask

  task automatic test_basic;
    int a0, o0, lat;
    a0 = n_acc; o0 = n_ovr;
    send_frame(0, 8'h55, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    wait_clks(BC);
    lat = rise_cyc - (frame_start + 10 * BC + BC / 2);
    tests++; if (n_acc - a0 != 1) begin fails++; $display("FAIL basic_words got %0d exp 1", n_acc - a0); end
    tests++; if (acc_data !== 8'h55) begin fails++; $display("FAIL basic_data got %h exp 55", acc_data); end
    tests++; if (acc_perr !== 1'b0) begin fails++; $display("FAIL basic_perr got %b exp 0", acc_perr); end
    tests++; if (acc_ferr !== 1'b0) begin fails++; $display("FAIL basic_ferr got %b exp 0", acc_ferr); end
    tests++; if (n_ovr - o0 != 0) begin fails++; $display("FAIL basic_overrun got %0d exp 0", n_ovr - o0); end
    tests++; if (lat < 0 || lat > 3) begin fails++; $display("FAIL basic_latency got %0d exp 0..3", lat); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_drop got %b exp 0", rx_valid); end
  endtask

  task automatic test_parity_err;
    int a0;
    a0 = n_acc;
    send_frame(0, 8'hA5, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    wait_clks(BC);
    tests++; if (n_acc - a0 != 1) begin fails++; $display("FAIL par_words got %0d exp 1", n_acc - a0); end
    tests++; if (acc_data !== 8'hA5) begin fails++; $display("FAIL par_data got %h exp a5", acc_data); end
    tests++; if (acc_perr !== 1'b1) begin fails++; $display("FAIL par_perr got %b exp 1", acc_perr); end
    tests++; if (acc_ferr !== 1'b0) begin fails++; $display("FAIL par_ferr got %b exp 0", acc_ferr); end
  endtask

  task automatic test_frame_err;
    int a0;
    a0 = n_acc;
    send_frame(0, 8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    wait_clks(BC);
    tests++; if (n_acc - a0 != 1) begin fails++; $display("FAIL frm_words got %0d exp 1", n_acc - a0); end
    tests++; if (acc_data !== 8'h3C) begin fails++; $display("FAIL frm_data got %h exp 3c", acc_data); end
    tests++; if (acc_ferr !== 1'b1) begin fails++; $display("FAIL frm_ferr got %b exp 1", acc_ferr); end
    tests++; if (acc_perr !== 1'b0) begin fails++; $display("FAIL frm_perr got %b exp 0", acc_perr); end
  endtask

  task automatic test_back_to_back;
    int a0, o0;
    @(negedge clk); rx_ready = 1'b0;
    a0 = n_acc; o0 = n_ovr;
    send_frame(0, 8'h11, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    send_frame(0, 8'h22, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    wait_clks(10);
    tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid_held got %b exp 1", rx_valid); end
    tests++; if (rx_data !== 8'h11) begin fails++; $display("FAIL ovr_data_held got %h exp 11", rx_data); end
    tests++; if (n_ovr - o0 != 1) begin fails++; $display("FAIL ovr_pulses got %0d exp 1", n_ovr - o0); end
    @(posedge clk); #1 rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL ovr_valid_drop got %b exp 0", rx_valid); end
    wait_clks(3 * BC);
    tests++; if (n_acc - a0 != 1) begin fails++; $display("FAIL ovr_words got %0d exp 1", n_acc - a0); end
    tests++; if (acc_data !== 8'h11) begin fails++; $display("FAIL ovr_acc_data got %h exp 11", acc_data); end
  endtask

  task automatic test_false_start;
    int a0, b0;
    a0 = n_acc; b0 = n_busy;
    @(negedge clk); rx_in = 1'b0;
    wait_clks(30);
    rx_in = 1'b1;
    wait_clks(2 * BC);
    tests++; if (n_busy - b0 <= 0) begin fails++; $display("FAIL glitch_busy_seen got %0d exp >0", n_busy - b0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_end got %b exp 0", busy); end
    tests++; if (n_acc - a0 != 0) begin fails++; $display("FAIL glitch_words got %0d exp 0", n_acc - a0); end
  endtask

  task automatic test_seven_n_two;
    send_frame(1, 8'h7F, 7, 1'b0, 1'b0, 1'b1, 1'b1, 2);
    wait_clks(10);
    tests++; if (rx_valid2 !== 1'b1) begin fails++; $display("FAIL n2_valid got %b exp 1", rx_valid2); end
    tests++; if (rx_data2 !== 8'h7F) begin fails++; $display("FAIL n2_data got %h exp 7f", rx_data2); end
    tests++; if ({parity_err2, frame_err2} !== 2'b00) begin
      fails++; $display("FAIL n2_flags got %b exp 00", {parity_err2, frame_err2});
    end
    @(posedge clk); #1 rx_ready2 = 1'b1;
    @(posedge clk); #1 rx_ready2 = 1'b0;
    @(negedge clk);
    tests++; if (rx_valid2 !== 1'b0) begin fails++; $display("FAIL n2_valid_drop got %b exp 0", rx_valid2); end
    send_frame(1, 8'h35, 7, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    wait_clks(10);
    tests++; if (rx_data2 !== 8'h35) begin fails++; $display("FAIL n2_stop2_data got %h exp 35", rx_data2); end
    tests++; if (frame_err2 !== 1'b1) begin fails++; $display("FAIL n2_stop2_ferr got %b exp 1", frame_err2); end
    wait_clks(BC);
  endtask

  task automatic test_reset_mid;
    int a0;
    @(negedge clk);
    rx_in = 1'b0; wait_clks(BC);
    rx_in = 1'b1; wait_clks(BC);
    rx_in = 1'b0; wait_clks(BC);
    rx_in = 1'b1; wait_clks(BC);
    rst = 1'b1;
    wait_clks(2);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL rstmid_data got %h exp 00", rx_data); end
    tests++; if ({rx_valid, overrun} !== 2'b00) begin
      fails++; $display("FAIL rstmid_valid_ovr got %b exp 00", {rx_valid, overrun});
    end
    wait_clks(5);
    rst = 1'b0;
    a0 = n_acc;
    wait_clks(BC);
    send_frame(0, 8'h5A, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    wait_clks(3 * BC);
    tests++; if (n_acc - a0 != 1) begin fails++; $display("FAIL rstmid_words got %0d exp 1", n_acc - a0); end
    tests++; if (acc_data !== 8'h5A) begin fails++; $display("FAIL rstmid_acc_data got %h exp 5a", acc_data); end
  endtask

  task automatic test_break;
    int a0, k0, o0;
    a0 = n_acc; k0 = n_brk; o0 = n_ovr;
    @(negedge clk); rx_in = 1'b0;
    wait_clks(19 * BC);
    tests++; if (busy !== (BRK_PULSES == 1)) begin
      fails++; $display("FAIL brk_busy_low got %b exp %b", busy, (BRK_PULSES == 1));
    end
    wait_clks(BC);
    rx_in = 1'b1;
    wait_clks(2 * BC);
    tests++; if (n_brk - k0 != BRK_PULSES) begin
      fails++; $display("FAIL brk_pulses got %0d exp %0d", n_brk - k0, BRK_PULSES);
    end
    tests++; if (n_acc - a0 != BRK_WORDS) begin
      fails++; $display("FAIL brk_words got %0d exp %0d", n_acc - a0, BRK_WORDS);
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL brk_busy_high got %b exp 0", busy); end
`ifndef UART_RX_BREAK_DET_EN
    tests++; if (acc_data !== 8'h00) begin fails++; $display("FAIL brk_data got %h exp 00", acc_data); end
    tests++; if ({acc_perr, acc_ferr} !== 2'b01) begin
      fails++; $display("FAIL brk_flags got %b exp 01", {acc_perr, acc_ferr});
    end
`endif
    send_frame(0, 8'h55, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    wait_clks(BC);
    tests++; if (n_acc - a0 != BRK_WORDS + 1) begin
      fails++; $display("FAIL brk_rearm_words got %0d exp %0d", n_acc - a0, BRK_WORDS + 1);
    end
    tests++; if (acc_data !== 8'h55) begin fails++; $display("FAIL brk_rearm_data got %h exp 55", acc_data); end
    tests++; if (n_ovr - o0 != 0) begin fails++; $display("FAIL brk_overrun got %0d exp 0", n_ovr - o0); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity_err;
    test_frame_err;
    test_back_to_back;
    test_false_start;
    test_seven_n_two;
    test_reset_mid;
    test_break;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
